// File: rtl/sp_ram_bw.sv
// Single-port synchronous RAM with per-byte write enables, 1- or 2-cycle read
// latency with a read-valid strobe, and a clear engine that zeroes the array.
module sp_ram_bw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int N_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;

    logic                    access_en;
    logic                    rd_en;
    logic                    mem_we;
    logic [N_BYTES-1:0]      mem_be;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic                    rd_valid_reg;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sp_ram_bw: DATA_WIDTH must be a multiple of 8");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == '1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // The clear engine owns the single write port while it runs; a clr edge
    // swallows any access presented alongside it.
    always_comb begin
        busy      = (state_reg == ST_CLEAR);
        access_en = (state_reg == ST_IDLE) && !clr;
        rd_en     = access_en && re;
        mem_we    = 1'b0;
        mem_be    = be;
        mem_waddr = addr;
        mem_wdata = data_in;
        if (state_reg == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_waddr = cnt_reg;
            mem_wdata = '0;
        end else if (access_en && we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < N_BYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Reads sample the array before the same-edge write lands (read-first).
    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_out_reg <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= rd_en;
                if (rd_en) begin
                    data_out_reg <= mem[addr];
                end
            end
        end
    end else if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data_reg;
        logic                  s1_valid_reg;

        always_ff @(posedge clk) begin
            if (rd_en) begin
                s1_data_reg <= mem[addr];
            end
        end

        // A read already in flight completes even if a clear starts behind it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid_reg <= 1'b0;
                data_out_reg <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                s1_valid_reg <= rd_en;
                rd_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    data_out_reg <= s1_data_reg;
                end
            end
        end
    end else begin : g_bad_latency
        $error("sp_ram_bw: RD_LATENCY must be 1 or 2");
    end

    assign data_out = data_out_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_sp_ram_bw.sv
// Randomised and directed bench for sp_ram_bw; a latency-1 and a latency-2
// instance share one stimulus stream and are checked against one memory model.
module tb_sp_ram_bw;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we, re, clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [3:0]    be;
    logic [DW-1:0] dout1, dout2;
    logic          v1, v2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sp_ram_bw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_in(data_in),
        .be(be), .clr(clr), .data_out(dout1), .rd_valid(v1), .busy(busy1)
    );

    sp_ram_bw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_in(data_in),
        .be(be), .clr(clr), .data_out(dout2), .rd_valid(v2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clear_left counts outstanding clear writes; reads are
    // results that emerge after the configured number of edges.
    logic [DW-1:0] mmem [DEPTH];
    int            clear_left;
    logic          exp_v1, exp_v2, pend_v, rd_now;
    logic [DW-1:0] exp_d1, exp_d2, pend_d, rd_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left = DEPTH;
            exp_v1 = 1'b0; exp_d1 = '0;
            exp_v2 = 1'b0; exp_d2 = '0;
            pend_v = 1'b0; pend_d = '0;
        end else begin
            rd_now = 1'b0;
            rd_val = '0;
            if (clear_left > 0) begin
                mmem[DEPTH - clear_left] = '0;
                clear_left--;
            end else if (clr) begin
                clear_left = DEPTH;
            end else begin
                if (re) begin
                    rd_now = 1'b1;
                    rd_val = mmem[addr];
                end
                if (we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) mmem[addr][8*i +: 8] = data_in[8*i +: 8];
                    end
                end
            end
            exp_v2 = pend_v;
            if (pend_v) exp_d2 = pend_d;
            pend_v = rd_now;
            if (rd_now) pend_d = rd_val;
            exp_v1 = rd_now;
            if (rd_now) exp_d1 = rd_val;
        end
    end

    always @(negedge clk) begin
        chk("busy_l1", {31'b0, busy1}, {31'b0, clear_left > 0});
        chk("busy_l2", {31'b0, busy2}, {31'b0, clear_left > 0});
        chk("rd_valid_l1", {31'b0, v1}, {31'b0, exp_v1});
        chk("rd_valid_l2", {31'b0, v2}, {31'b0, exp_v2});
        chk("data_out_l1", dout1, exp_d1);
        chk("data_out_l2", dout2, exp_d2);
    end

    task automatic step(input logic w, input logic r, input logic c,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        we = w; re = r; clr = c; addr = a; data_in = d; be = b;
        @(posedge clk);
        #1;
        $display("txn t=%0t we=%0b re=%0b clr=%0b addr=%0d din=%h be=%h | l1 v=%0b d=%h l2 v=%0b d=%h busy=%0b",
                 $time, w, r, c, a, d, b, v1, dout1, v2, dout2, busy1);
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    // Hold reset with reads requested, release, and count the clear edges.
    task automatic reset_and_count(input string name);
        int n;
        int vc;
        vc = 0;
        rst = 1'b1;
        we = 1'b0; re = 1'b1; clr = 1'b0;
        #1;
        vc += int'(v1) + int'(v2);
        repeat (2) begin
            @(posedge clk); #1;
            vc += int'(v1) + int'(v2);
        end
        chk({name, "_rst_busy"}, {31'b0, busy1}, 32'd1);
        chk({name, "_rst_dout"}, dout2, 32'd0);
        rst = 1'b0;
        n = 0;
        while (busy1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            vc += int'(v1) + int'(v2);
        end
        re = 1'b0;
        chk({name, "_busy_edges"}, n, 32'd16);
        chk({name, "_no_rd_valid"}, vc, 32'd0);
        $display("txn t=%0t %s busy_edges=%0d", $time, name, n);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0;
        addr = '0; data_in = '0; be = '0;
        #1;

        reset_and_count("por");

        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b1, 1'b0, AW'(a), 32'h0, 4'h0);
            chk("init_zero", dout1, 32'h0000_0000);
            chk("init_valid", {31'b0, v1}, 32'd1);
        end

        step(1'b1, 1'b0, 1'b0, 4'd3, 32'hDEAD_BEEF, 4'hF);
        step(1'b1, 1'b0, 1'b0, 4'd3, 32'h1122_3344, 4'b0101);
        step(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        chk("byte_enable", dout1, 32'hDE22_BE44);
        step(1'b1, 1'b0, 1'b0, 4'd3, 32'hFFFF_FFFF, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        chk("be_zero_noop", dout1, 32'hDE22_BE44);

        step(1'b1, 1'b0, 1'b0, 4'd5, 32'hA5A5_A5A5, 4'hF);
        step(1'b1, 1'b1, 1'b0, 4'd5, 32'h0F0F_0F0F, 4'hF);
        chk("read_first", dout1, 32'hA5A5_A5A5);
        step(1'b0, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        chk("after_write", dout1, 32'h0F0F_0F0F);

        for (int a = 1; a <= 3; a++) step(1'b1, 1'b0, 1'b0, AW'(a), DW'(a), 4'hF);
        step(1'b0, 1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
        chk("l2_lat_v0", {31'b0, v2}, 32'd0);
        chk("l1_rd1", dout1, 32'h1);
        step(1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
        chk("l2_rd1_v", {31'b0, v2}, 32'd1);
        chk("l2_rd1", dout2, 32'h1);
        step(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        chk("l2_rd2", dout2, 32'h2);
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        chk("l2_rd3", dout2, 32'h3);
        chk("l2_rd3_v", {31'b0, v2}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        chk("l2_done_v", {31'b0, v2}, 32'd0);
        chk("l2_hold", dout2, 32'h3);

        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 1'b0, AW'(a), 32'h0101_0101 * (a + 1), 4'hF);
        // read in flight in the latency-2 pipe when clr lands still completes
        step(1'b0, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'd2, 32'hCAFE_F00D, 4'hF);
        chk("clr_busy", {31'b0, busy1}, 32'd1);
        chk("clr_inflight", dout2, 32'h0808_0808);
        n = 0;
        while (busy1 && n < 100) begin
            we = 1'b1; re = 1'b1; clr = 1'($urandom_range(0, 1));
            addr = AW'($urandom); data_in = $urandom; be = 4'hF;
            @(posedge clk); #1;
            n++;
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
        chk("clr_busy_edges", n, 32'd16);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b1, 1'b0, AW'(a), 32'h0, 4'h0);
            chk("clr_zero", dout1, 32'h0);
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0),
                 AW'($urandom), DW'($urandom), 4'($urandom));
        end

        wait_idle();
        step(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        reset_and_count("mid_read_rst");

        step(1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
        repeat (7) step(1'b1, 1'b1, 1'b0, AW'($urandom), DW'($urandom), 4'hF);
        reset_and_count("mid_clear_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sp_ram_bw.md
Name: sp_ram_bw

Overview:
- Parametrised single-port synchronous SRAM; next-generation replacement for the plain single-port RAM.
- Adds per-byte write enables, a selectable 1- or 2-cycle read latency with a read-valid strobe, and a hardware clear engine.
- The clear engine zeroes the whole array after reset or on request, with `busy` flagged while it runs.
- Sits behind a simple we/re/addr master; the master must wait for `busy` low before issuing accesses.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6: address width; DEPTH = 2**ADDR_WIDTH words.
- RD_LATENCY, 1: read latency in clock edges; legal values are 1 or 2 only, anything else is an elaboration error.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write request.
- re  input  1  read request.
- addr  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- be  input  DATA_WIDTH/8  byte enables; bit i covers data_in[8i+7:8i].
- clr  input  1  request a full-array clear; single-cycle pulse.
- data_out  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  one-cycle strobe; data_out holds new read data while it is high.
- busy  output  1  clear in progress; accesses are ignored while high.

Behaviour:
- Reset (async assert, sync release):
  - data_out=0, rd_valid=0, busy=1, FSM=CLEAR, clear counter=0, read pipeline flushed.
  - Memory array has no reset; the CLEAR sequence zeroes it.
- FSM states: CLEAR, IDLE.
  - CLEAR: each rising edge writes 0 to mem[cnt] and increments cnt.
  - The edge that writes DEPTH-1 moves the FSM to IDLE and drives busy=0 (registered).
  - busy is therefore high for exactly DEPTH rising edges after reset release.
- clr sampled high in IDLE at edge E:
  - FSM goes to CLEAR and busy=1 after E; cnt=0. Any we/re in that cycle is ignored.
  - Clear writes address 0 at E+1 through DEPTH-1 at E+DEPTH; busy=0 after E+DEPTH.
- While busy=1: we, re and clr are ignored. No memory change except clear writes. No new rd_valid.
- Write (IDLE, we=1): at the edge, mem[addr] byte i is set to data_in byte i for every be[i]=1; the other bytes are unchanged. be=0 is a legal no-op write.
- Read (IDLE, re=1): array is read at the sampling edge S.
  - RD_LATENCY=1: data_out and rd_valid=1 update at S.
  - RD_LATENCY=2: an intermediate register is loaded at S; data_out and rd_valid=1 update at S+1.
  - Back-to-back reads sustain one result per cycle at either latency.
- we=1 and re=1 at the same edge: read-first. data_out returns the pre-write contents; the write also takes effect.
- data_out holds its last value when no read completes. rd_valid is 0 on every cycle without a completing read.
- A read already in the latency-2 pipeline when clr is sampled still completes normally, with data captured before the clear.
- rst mid-operation (mid-clear or mid-read): the pipeline is flushed, the clear restarts at address 0, and rd_valid never fires for the flushed read.
- Address space is the full 2**ADDR_WIDTH, so there is no out-of-range case.

Test Plan:
- Test configuration: DATA_WIDTH=32, ADDR_WIDTH=4, RD_LATENCY=1.
- Reset release → busy high for 16 edges then low; reading addresses 0..15 → data_out=0x00000000 with rd_valid=1 each cycle.
- Write addr 3 = 0xDEADBEEF with be=4'hF, then write addr 3 data 0x11223344 with be=4'b0101 → read addr 3 gives 0xDE22BE44.
- Same edge we=1, re=1, addr 5 (old 0xA5A5A5A5, new 0x0F0F0F0F) → data_out=0xA5A5A5A5; a following read → 0x0F0F0F0F.
- RD_LATENCY=2: reads of addr 1,2,3 on consecutive edges (contents 0x1,0x2,0x3) → rd_valid high for 3 cycles starting one edge later, data_out 0x1,0x2,0x3 in order.
- Fill addresses 0..15 with nonzero data, pulse clr → busy high for 16 edges after the clr edge; we issued during busy has no effect; all reads afterwards return 0.
- Assert rst when the clear counter is at 7 → busy stays high, the clear restarts at 0, busy drops 16 edges after release, rd_valid stays 0 throughout.
